bit_mask_drain_64: RTL and testbench



---
 rtl/bit_mask_drain_64.sv | 75 +++++++
 tb/tb_bit_mask_drain_64.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/bit_mask_drain_64.sv
// Iterative set-bit extractor: loads a mask once, then emits the index of each
// set bit, lowest first, one per accepted valid/ready transfer.
module bit_mask_drain_64 #(
   parameter int WIDTH = 64,
   parameter int IDX_W = 6
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_mask,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [IDX_W-1:0] out_index,
   output logic             out_last,
   output logic             done,
   output logic [IDX_W:0]   count
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] DRAIN = 2'd1;
   localparam logic [1:0] DONE  = 2'd2;

   logic [1:0]       state;
   logic [WIDTH-1:0] remaining;
   logic [IDX_W-1:0] low_idx;
   logic             one_left;

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      low_idx = '0;
      for (int i = WIDTH - 1; i >= 0; i--) begin
         if (remaining[i]) low_idx = i[IDX_W-1:0];
      end
   end

   // Exactly one bit set: non-zero and clearing the lowest bit leaves nothing.
   assign one_left = (remaining != '0) &&
                     ((remaining & (remaining - WIDTH'(1))) == '0);

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DRAIN);
   assign out_index = out_valid ? low_idx : '0;
   assign out_last  = out_valid && one_left;
   assign done      = (state == DONE);

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         remaining <= '0;
         count     <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  remaining <= in_mask;
                  count     <= '0;
                  state     <= (in_mask != '0) ? DRAIN : DONE;
               end
            end
            DRAIN: begin
               if (out_ready) begin
                  remaining[low_idx] <= 1'b0;
                  count              <= count + (IDX_W+1)'(1);
                  if (one_left) state <= DONE;
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_bit_mask_drain_64.sv
// Directed testbench for bit_mask_drain_64: one task per scenario, inline checks,
// single summary line at the end.
module tb_bit_mask_drain_64;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [63:0] in_mask;
   logic        out_valid;
   logic        out_ready;
   logic [5:0]  out_index;
   logic        out_last;
   logic        done;
   logic [6:0]  count;

   int total = 0;
   int bad   = 0;

   bit_mask_drain_64 dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_mask   (in_mask),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_index (out_index),
      .out_last  (out_last),
      .done      (done),
      .count     (count)
   );

   always #5 clk = ~clk;

   // Advance one edge and settle just after it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Offer a mask for exactly one edge; the block must be idle beforehand.
   task automatic load(input logic [63:0] m);
      total++;
      if (in_ready !== 1'b1) begin
         bad++;
         $display("FAIL load_ready: in_ready=%b want 1", in_ready);
      end
      in_valid = 1'b1;
      in_mask  = m;
      step();
      in_valid = 1'b0;
      in_mask  = '0;
   endtask

   // Compare the output-side signals against expectations for one cycle.
   task automatic expect_out(input string tag, input logic v, input logic [5:0] idx,
                             input logic last, input logic dn);
      total++;
      if (out_valid !== v || out_index !== idx || out_last !== last || done !== dn) begin
         bad++;
         $display("FAIL %s: valid=%b idx=%0d last=%b done=%b want valid=%b idx=%0d last=%b done=%b",
                  tag, out_valid, out_index, out_last, done, v, idx, last, dn);
      end
   endtask

   task automatic expect_count(input string tag, input logic [6:0] c);
      total++;
      if (count !== c) begin
         bad++;
         $display("FAIL %s: count=%0d want %0d", tag, count, c);
      end
   endtask

   task automatic test_reset();
      reset     = 1'b1;
      in_valid  = 1'b0;
      in_mask   = '0;
      out_ready = 1'b0;
      #1;
      expect_out("reset_out", 1'b0, 6'd0, 1'b0, 1'b0);
      expect_count("reset_count", 7'd0);
      total++;
      if (in_ready !== 1'b1) begin
         bad++;
         $display("FAIL reset_in_ready: in_ready=%b want 1", in_ready);
      end
      step();
      step();
      reset = 1'b0;
      step();
   endtask

   task automatic test_basic();
      out_ready = 1'b1;
      load(64'h5);
      expect_out("basic_n1", 1'b1, 6'd0, 1'b0, 1'b0);
      step();
      expect_out("basic_n2", 1'b1, 6'd2, 1'b1, 1'b0);
      step();
      expect_out("basic_done", 1'b0, 6'd0, 1'b0, 1'b1);
      expect_count("basic_count", 7'd2);
      total++;
      if (in_ready !== 1'b0) begin
         bad++;
         $display("FAIL basic_done_ready: in_ready=%b want 0", in_ready);
      end
      step();
      total++;
      if (in_ready !== 1'b1 || done !== 1'b0) begin
         bad++;
         $display("FAIL basic_idle: in_ready=%b done=%b want 1 0", in_ready, done);
      end
      expect_count("basic_count_hold", 7'd2);
   endtask

   task automatic test_zero_mask();
      load(64'h0);
      expect_out("zero_done", 1'b0, 6'd0, 1'b0, 1'b1);
      expect_count("zero_count", 7'd0);
      step();
      total++;
      if (in_ready !== 1'b1 || done !== 1'b0 || out_valid !== 1'b0) begin
         bad++;
         $display("FAIL zero_idle: in_ready=%b done=%b valid=%b want 1 0 0",
                  in_ready, done, out_valid);
      end
   endtask

   task automatic test_all_ones();
      out_ready = 1'b1;
      load({64{1'b1}});
      for (int i = 0; i < 64; i++) begin
         expect_out($sformatf("ones_%0d", i), 1'b1, 6'(i), (i == 63), 1'b0);
         step();
      end
      expect_out("ones_done", 1'b0, 6'd0, 1'b0, 1'b1);
      expect_count("ones_count", 7'd64);
      step();
   endtask

   task automatic test_backpressure();
      out_ready = 1'b0;
      load(64'h8000_0000_0000_0001);
      for (int k = 0; k < 3; k++) begin
         expect_out($sformatf("bp_hold_%0d", k), 1'b1, 6'd0, 1'b0, 1'b0);
         expect_count($sformatf("bp_count_%0d", k), 7'd0);
         step();
      end
      out_ready = 1'b1;
      #1;
      expect_out("bp_first", 1'b1, 6'd0, 1'b0, 1'b0);
      step();
      expect_out("bp_last", 1'b1, 6'd63, 1'b1, 1'b0);
      expect_count("bp_count_mid", 7'd1);
      step();
      expect_out("bp_done", 1'b0, 6'd0, 1'b0, 1'b1);
      expect_count("bp_count", 7'd2);
      step();
   endtask

   task automatic test_ignore_load_in_drain();
      out_ready = 1'b1;
      load(64'h30);
      in_valid = 1'b1;
      in_mask  = 64'hFF;
      #1;
      total++;
      if (in_ready !== 1'b0) begin
         bad++;
         $display("FAIL ign_ready: in_ready=%b want 0", in_ready);
      end
      expect_out("ign_n1", 1'b1, 6'd4, 1'b0, 1'b0);
      step();
      expect_out("ign_n2", 1'b1, 6'd5, 1'b1, 1'b0);
      step();
      in_valid = 1'b0;
      in_mask  = '0;
      expect_out("ign_done", 1'b0, 6'd0, 1'b0, 1'b1);
      expect_count("ign_count", 7'd2);
      step();
   endtask

   task automatic test_reset_mid_drain();
      out_ready = 1'b1;
      load(64'hF0);
      expect_out("rst_n1", 1'b1, 6'd4, 1'b0, 1'b0);
      step();
      expect_out("rst_n2", 1'b1, 6'd5, 1'b0, 1'b0);
      expect_count("rst_count_pre", 7'd1);
      #1;
      reset = 1'b1;
      #1;
      expect_out("rst_async", 1'b0, 6'd0, 1'b0, 1'b0);
      expect_count("rst_async_count", 7'd0);
      step();
      reset = 1'b0;
      expect_out("rst_no_done", 1'b0, 6'd0, 1'b0, 1'b0);
      load(64'h2);
      expect_out("rst_reload", 1'b1, 6'd1, 1'b1, 1'b0);
      step();
      expect_out("rst_reload_done", 1'b0, 6'd0, 1'b0, 1'b1);
      expect_count("rst_reload_count", 7'd1);
      step();
   endtask

   initial begin
      test_reset();
      test_basic();
      test_zero_mask();
      test_all_ones();
      test_backpressure();
      test_ignore_load_in_drain();
      test_reset_mid_drain();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
